// File: rtl/seq_stim_tx.sv
// -----------------------------------------------------------------------------
// seq_stim_tx
//
// Serial stimulus transmitter for the sequence-detector FSMs. A parallel
// pattern is captured on an accepted start and shifted out on x one bit per
// clock, either MSB-first or LSB-first. Detector pulses fed back on hit are
// counted, with saturation, while the transfer is in flight. One extra FLUSH
// cycle after the last bit lets a Mealy or Moore detector react to that bit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = reset asserted)
//   start      transfer request, sampled only in IDLE
//   pattern    bits to send, captured on start acceptance
//   len        number of bits to send, clamped to WIDTH
//   msb_first  1: pattern[len-1] first; 0: pattern[0] first
//   idle_bit   level driven on x whenever no pattern bit is being sent
//   hit        detector output fed back for counting
//   x          registered serial bit to the detector
//   busy       high in SEND and FLUSH
//   done       one-cycle pulse while in DONE
//   bit_idx    index of the bit currently on x (0 = first bit sent)
//   hit_count  saturating count of hit samples taken in SEND and FLUSH
//   state      FSM state encoding, exported for monitoring
// -----------------------------------------------------------------------------
module seq_stim_tx #(
  parameter int WIDTH = 18,  // maximum pattern length in bits
  parameter int LEN_W = 5,   // width of len and bit_idx; 2**LEN_W > WIDTH
  parameter int CNT_W = 8    // width of the saturating hit counter
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             msb_first,
  input  logic             idle_bit,
  input  logic             hit,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx,
  output logic [CNT_W-1:0] hit_count,
  output logic [1:0]       state
);

  // ---------------------------------------------------------------------------
  // State encoding (exported on the state port, so the values are fixed)
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SEND  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic             x_q,         x_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [LEN_W-1:0] bit_idx_q,   bit_idx_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [WIDTH-1:0] pat_q,       pat_d;     // captured pattern
  logic [LEN_W-1:0] len_q,       len_d;     // captured, clamped length
  logic             msb_q,       msb_d;     // captured bit order

  // ---------------------------------------------------------------------------
  // Bit selection helper
  //
  // An explicit compare-and-select mux instead of vec[pos]: pos is LEN_W bits
  // wide and can address past WIDTH-1, and this form returns a defined 0 for
  // such positions rather than an out-of-range read.
  // ---------------------------------------------------------------------------
  function automatic logic pick_bit(input logic [WIDTH-1:0] vec,
                                    input logic [LEN_W-1:0] pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos == LEN_W'(i)) b = vec[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Start-acceptance datapath (operates on the live inputs)
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] first_pos;
  logic             first_bit;

  assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;
  // For len==0 first_pos wraps, but first_bit is never used in that case.
  assign first_pos   = msb_first ? (len_clamped - ONE_L) : '0;
  assign first_bit   = pick_bit(pattern, first_pos);

  // ---------------------------------------------------------------------------
  // In-flight datapath (operates on the captured copies)
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] next_idx;
  logic [LEN_W-1:0] next_pos;
  logic             next_bit;
  logic             last_bit;

  assign next_idx = bit_idx_q + ONE_L;
  // MSB-first walks down from len-1, LSB-first walks up from 0.
  assign next_pos = msb_q ? (len_q - ONE_L - next_idx) : next_idx;
  assign next_bit = pick_bit(pat_q, next_pos);
  assign last_bit = (bit_idx_q == (len_q - ONE_L));

  // ---------------------------------------------------------------------------
  // Hit counter: one sample per edge in SEND or FLUSH, saturating at all-ones
  // ---------------------------------------------------------------------------
  logic counting;
  logic cnt_full;

  assign counting = (state_q == ST_SEND) || (state_q == ST_FLUSH);
  assign cnt_full = &hit_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    x_d         = idle_bit;
    bit_idx_d   = bit_idx_q;
    hit_count_d = hit_count_q;
    pat_d       = pat_q;
    len_d       = len_q;
    msb_d       = msb_q;

    if (counting && hit && !cnt_full) begin
      hit_count_d = hit_count_q + ONE_C;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d       = pattern;
          msb_d       = msb_first;
          len_d       = len_clamped;
          hit_count_d = '0;
          bit_idx_d   = '0;
          if (len_clamped != '0) begin
            state_d = ST_SEND;
            x_d     = first_bit;
          end else begin
            // Empty transfer: skip straight to the done pulse.
            state_d = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        if (last_bit) begin
          // The last bit has had its full cycle; x returns to idle_bit.
          state_d = ST_FLUSH;
        end else begin
          bit_idx_d = next_idx;
          x_d       = next_bit;
        end
      end

      ST_FLUSH: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        bit_idx_d = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = '0;
      end
    endcase
  end

  // busy and done are registered from the next state so they are glitch-free
  // and line up exactly with the exported state.
  assign busy_d = (state_d == ST_SEND) || (state_d == ST_FLUSH);
  assign done_d = (state_d == ST_DONE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_idx_q   <= '0;
      hit_count_q <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      msb_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed before this edge, independent of statement order.
      state_q     <= state_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_idx_q   <= bit_idx_d;
      hit_count_q <= hit_count_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_idx   = bit_idx_q;
  assign hit_count = hit_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_stim_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_stim_tx
//
// Self-checking bench for seq_stim_tx. Expected serial bits are pushed onto a
// queue when a transfer is started and popped as the DUT presents them on x.
// A second instance with a 2-bit hit counter shares the stimulus to exercise
// counter saturation. Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_stim_tx;

  localparam int WIDTH = 18;
  localparam int LEN_W = 5;
  localparam int CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SEND  = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             msb_first;
  logic             idle_bit;
  logic             hit_drv;
  logic             loopback;
  logic             hit;

  logic             x, busy, done;
  logic [LEN_W-1:0] bit_idx;
  logic [CNT_W-1:0] hit_count;
  logic [1:0]       state;

  logic             x2, busy2, done2;
  logic [LEN_W-1:0] bit_idx2;
  logic [1:0]       hit_count2;
  logic [1:0]       state2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic exp_q[$];

  // Loopback mode stands in for a detector that pulses whenever x is 1.
  assign hit = loopback ? x : hit_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_stim_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .msb_first(msb_first), .idle_bit(idle_bit), .hit(hit),
    .x(x), .busy(busy), .done(done), .bit_idx(bit_idx),
    .hit_count(hit_count), .state(state)
  );

  seq_stim_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .msb_first(msb_first), .idle_bit(idle_bit), .hit(hit),
    .x(x2), .busy(busy2), .done(done2), .bit_idx(bit_idx2),
    .hit_count(hit_count2), .state(state2)
  );

  // Drive a start at the current falling edge, queue the expected bits, and
  // return at the falling edge after acceptance (bit 0 should be on x).
  task automatic start_xfer(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] l,
                            input logic msb);
    int lc;
    lc = (int'(l) > WIDTH) ? WIDTH : int'(l);
    pattern   = pat;
    len       = l;
    msb_first = msb;
    start     = 1'b1;
    for (int i = 0; i < lc; i++) exp_q.push_back(msb ? pat[lc-1-i] : pat[i]);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow a transfer from bit 0 to the falling edge that shows IDLE again.
  // exp_hits < 0 skips the hit count check; poke_at >= 0 issues a stray start
  // and scrambles the inputs while that bit is on x.
  task automatic follow_xfer(input int lc, input int exp_hits, input int poke_at,
                             output int busy_cycles);
    logic e;
    logic poked;
    busy_cycles = 0;
    for (int i = 0; i < lc; i++) begin
      poked = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty bit=%0d", i);
      end else begin
        e = exp_q.pop_front();
        if (x !== e || state !== S_SEND || bit_idx !== LEN_W'(i)) begin
          errors++;
          $display("FAIL send_bit[%0d] got x=%b state=%b idx=%0d want x=%b state=01 idx=%0d",
                   i, x, state, bit_idx, e, i);
        end
      end
      if (busy === 1'b1) busy_cycles++;
      if (i == poke_at) begin
        start     = 1'b1;
        pattern   = ~pattern;
        len       = 5'd3;
        msb_first = ~msb_first;
        poked     = 1'b1;
      end
      @(negedge clk);
      if (poked) start = 1'b0;
    end
    checks++;
    if (state !== S_FLUSH || x !== idle_bit || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush got state=%b x=%b busy=%b done=%b want 10 %b 1 0",
               state, x, busy, done, idle_bit);
    end
    if (busy === 1'b1) busy_cycles++;
    @(negedge clk);
    checks++;
    if (state !== S_DONE || done !== 1'b1 || busy !== 1'b0 || x !== idle_bit ||
        bit_idx !== LEN_W'(lc - 1)) begin
      errors++;
      $display("FAIL done_cycle got state=%b done=%b busy=%b x=%b idx=%0d want 11 1 0 %b %0d",
               state, done, busy, x, bit_idx, idle_bit, lc - 1);
    end
    if (exp_hits >= 0) begin
      checks++;
      if (hit_count !== CNT_W'(exp_hits)) begin
        errors++;
        $display("FAIL hit_count_done got %0d want %0d", hit_count, exp_hits);
      end
    end
    @(negedge clk);
    checks++;
    if (state !== S_IDLE || done !== 1'b0 || bit_idx !== '0) begin
      errors++;
      $display("FAIL back_to_idle got state=%b done=%b idx=%0d want 00 0 0",
               state, done, bit_idx);
    end
    if (exp_hits >= 0) begin
      checks++;
      if (hit_count !== CNT_W'(exp_hits)) begin
        errors++;
        $display("FAIL hit_count_held got %0d want %0d", hit_count, exp_hits);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pattern = '0; len = '0; msb_first = 1'b0;
    idle_bit = 1'b1; hit_drv = 1'b0; loopback = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== S_IDLE ||
        bit_idx !== '0 || hit_count !== '0) begin
      errors++;
      $display("FAIL reset_values got x=%b busy=%b done=%b state=%b idx=%0d cnt=%0d want all 0",
               x, busy, done, state, bit_idx, hit_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 1'b1 || state !== S_IDLE) begin
      errors++;
      $display("FAIL idle_follow got x=%b state=%b want 1 00", x, state);
    end
  endtask

  task automatic test_serial_order();
    int bc;
    idle_bit = 1'b0;
    @(negedge clk);
    start_xfer(18'b011110101111100010, 5'd18, 1'b1);
    follow_xfer(18, -1, -1, bc);
  endtask

  task automatic test_lsb_clamp();
    int bc;
    idle_bit = 1'b0;
    start_xfer(18'h00005, 5'd31, 1'b0);
    follow_xfer(18, -1, -1, bc);
    checks++;
    if (bc != 19) begin
      errors++;
      $display("FAIL busy_cycles got %0d want 19", bc);
    end
  endtask

  task automatic test_hit_count();
    int bc;
    int ones;
    logic [WIDTH-1:0] p;
    hit_drv = 1'b1;
    start_xfer(18'h2A5C3, 5'd8, 1'b1);
    follow_xfer(8, 9, -1, bc);
    checks++;
    if (hit_count2 !== 2'd3) begin
      errors++;
      $display("FAIL hit_count_saturate got %0d want 3", hit_count2);
    end
    // Loopback: hits are the ones on x in SEND plus idle_bit in FLUSH.
    hit_drv  = 1'b0;
    loopback = 1'b1;
    idle_bit = 1'b1;
    p        = 18'h1B2D6;
    ones     = 1;
    for (int i = 0; i < 12; i++) ones += int'(p[i]);
    @(negedge clk);
    start_xfer(p, 5'd12, 1'b0);
    follow_xfer(12, ones, -1, bc);
    loopback = 1'b0;
  endtask

  task automatic test_len_zero_and_ignored_start();
    int bc;
    hit_drv  = 1'b1;
    idle_bit = 1'b1;
    pattern  = 18'h3FFFF;
    len      = 5'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state !== S_DONE || done !== 1'b1 || x !== 1'b1 || busy !== 1'b0 ||
        hit_count !== '0) begin
      errors++;
      $display("FAIL len0_done got state=%b done=%b x=%b busy=%b cnt=%0d want 11 1 1 0 0",
               state, done, x, busy, hit_count);
    end
    @(negedge clk);
    checks++;
    if (state !== S_IDLE || done !== 1'b0 || x !== 1'b1) begin
      errors++;
      $display("FAIL len0_idle got state=%b done=%b x=%b want 00 0 1", state, done, x);
    end
    idle_bit = 1'b0;
    start_xfer(18'h000C9, 5'd8, 1'b1);
    follow_xfer(8, 9, 3, bc);
    @(negedge clk);
    checks++;
    if (state !== S_IDLE || x !== 1'b0) begin
      errors++;
      $display("FAIL no_restart got state=%b x=%b want 00 0", state, x);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    hit_drv  = 1'b1;
    idle_bit = 1'b1;
    start_xfer(18'h003FF, 5'd10, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (bit_idx !== 5'd5 || hit_count !== 8'd5) begin
      errors++;
      $display("FAIL pre_reset got idx=%0d cnt=%0d want 5 5", bit_idx, hit_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || state !== S_IDLE || hit_count !== '0 ||
        bit_idx !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got x=%b busy=%b state=%b cnt=%0d idx=%0d done=%b want all 0",
               x, busy, state, hit_count, bit_idx, done);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || state !== S_IDLE) begin
        errors++;
        $display("FAIL in_reset[%0d] got done=%b state=%b want 0 00", i, done, state);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 1'b1 || state !== S_IDLE || done !== 1'b0) begin
      errors++;
      $display("FAIL after_release got x=%b state=%b done=%b want 1 00 0", x, state, done);
    end
    start_xfer(18'h0002B, 5'd6, 1'b1);
    follow_xfer(6, 7, -1, bc);
  endtask

  task automatic test_back_to_back();
    int bc;
    int t_prev;
    hit_drv   = 1'b1;
    idle_bit  = 1'b0;
    pattern   = 18'h00009;
    len       = 5'd4;
    msb_first = 1'b1;
    start     = 1'b1;
    t_prev    = 0;
    for (int t = 0; t < 3; t++) begin
      exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      @(negedge clk);
      checks++;
      if (state !== S_SEND || hit_count !== '0) begin
        errors++;
        $display("FAIL b2b_accept[%0d] got state=%b cnt=%0d want 01 0", t, state, hit_count);
      end
      if (t > 0) begin
        checks++;
        if (cyc - t_prev != 7) begin
          errors++;
          $display("FAIL b2b_period[%0d] got %0d want 7", t, cyc - t_prev);
        end
      end
      t_prev = cyc;
      follow_xfer(4, 5, -1, bc);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_serial_order();
    test_lsb_clamp();
    test_hit_count();
    test_len_zero_and_ignored_start();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stim_tx.md
Name: seq_stim_tx

Overview:
Serial stimulus transmitter that drives the single-bit x stream consumed by the sequence-detector FSMs in top. It serializes a parallel-loaded pattern one bit per clock and counts the detector pulses fed back on hit during the transfer. It replaces hand-timed x toggling in benches and is the source end of the x/Y detector interface in the project_2 datapath.

Parameters:
WIDTH, 18, maximum pattern length in bits
LEN_W, 5, width of len and bit_idx; must satisfy 2^LEN_W > WIDTH
CNT_W, 8, width of the saturating hit counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request to transmit; sampled only in IDLE
pattern  input  WIDTH  bits to send; captured on start acceptance
len  input  LEN_W  number of bits to send; values above WIDTH are clamped to WIDTH
msb_first  input  1  1: send pattern[len-1] first, down to pattern[0]; 0: send pattern[0] first, up to pattern[len-1]; captured with pattern
idle_bit  input  1  level driven on x when not sending
hit  input  1  detector output (Y1 or Y2) fed back for counting
x  output  1  serial bit to the detector; registered
busy  output  1  high in SEND and FLUSH
done  output  1  one-cycle pulse in DONE
bit_idx  output  LEN_W  index of the bit currently on x (0 = first bit sent)
hit_count  output  CNT_W  saturating count of hit samples taken during the transfer
state  output  2  FSM state encoding, exported for monitoring

Behaviour:
- Reset (asynchronous, reset==0): state=IDLE, x=0, busy=0, done=0, bit_idx=0, hit_count=0, shift register and captured len cleared. While in reset, x stays 0; after reset release it follows idle_bit from the first clock edge.
- States: IDLE=2'b00, SEND=2'b01, FLUSH=2'b10, DONE=2'b11.
- IDLE: x<=idle_bit every edge. At edge k with start=1: capture pattern, msb_first and clamp(len); clear hit_count.
  - If the clamped len is nonzero: go to SEND with x<=first bit and bit_idx<=0.
  - If len==0: go directly to DONE; x stays idle_bit and hit_count stays 0.
- SEND: at each edge, if bit_idx==L-1 go to FLUSH with x<=idle_bit; otherwise present the next bit and increment bit_idx. Bit i is therefore on x during cycle [k+i, k+i+1). The last bit is held one cycle, then x returns to idle_bit at edge k+L.
- FLUSH: one cycle. Gives a Mealy or Moore detector time to react to the last bit. Next edge: go to DONE and set done<=1.
- DONE: done=1 for exactly one cycle. Next edge: go to IDLE and set done<=0.
- hit counting: at every edge where state is SEND or FLUSH (edges k+1 through k+L+1, i.e. L+1 samples), hit_count<=hit_count+hit. The count saturates at 2^CNT_W-1 and never wraps. It is held through DONE and IDLE until the next accepted start.
- start while busy or in DONE: ignored; the in-flight transfer is unaffected. pattern, len and msb_first changes after capture have no effect.
- start held high continuously: a new transfer is accepted on the first IDLE edge. Back-to-back transfers therefore have a period of L+3 cycles.
- bit_idx: holds L-1 in FLUSH and DONE, and is cleared to 0 on entry to IDLE.
- Reset asserted mid-transfer: immediate return to reset values. No done pulse is produced and the transfer is not resumed.

Test Plan:
1. Serial order: WIDTH=18, len=18, msb_first=1, pattern=18'b011110101111100010, idle_bit=0, start pulsed at edge 0 -> on edges 0..17, x = 0,1,1,1,1,0,1,0,1,1,1,1,1,0,0,0,1,0; x=0 and state=FLUSH at edge 18; done=1 only during cycle 19-20; state=IDLE at edge 20.
2. LSB-first and clamp: pattern=18'h00005, len=31, msb_first=0 -> len clamped to 18; x = 1,0,1 followed by fifteen 0s; busy high for 19 cycles.
3. Hit counting and saturation: hit tied 1, len=8 -> hit_count=9. Repeat with CNT_W=2 -> hit_count=3 and it does not wrap. Loopback of x through the detector FSMs yields a count equal to the detector pulses observed in FLUSH-inclusive cycles.
4. len=0 and ignored start: start with len=0 -> DONE on the next edge, done pulse, hit_count=0, x never leaves idle_bit. start pulsed at bit 3 of a len=8 transfer -> no restart and bit sequence unchanged.
5. Reset mid-operation: reset driven to 0 asynchronously at bit 5 of 10 -> x=0, busy=0, state=00, hit_count=0 immediately with no clock edge; no done pulse. After release, start works normally.
6. Back-to-back: start held 1 with len=4 -> transfers begin every 7 cycles; hit_count is cleared at each acceptance.
